axil_sram_resp: RTL and testbench
=================================

Name: axil_sram_resp

Overview:
- AXI-lite style responder: the memory end of the bus driven by the core's fetch/LSU arbiter.
- Serves single-beat reads (AR/R) and writes (AW/W/B) from an internal word-organised SRAM model.
- Reads and writes are handled by two independent channel FSMs, each with a programmable response latency.
- Sits between the arbiter's AXI port and nothing else. It is the simulation/FPGA main memory for the single-cycle/multi-cycle core.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from the accepting handshake to response valid; 0 is legal.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ar_valid  in  1  read address valid
- ar_addr  in  32  read byte address
- ar_strb  in  3  read size code (see Behaviour)
- ar_ready  out  1  read address accepted
- r_valid  out  1  read data valid
- r_data  out  32  read data, lane-extracted and extended
- r_ready  in  1  master accepts read data
- aw_valid  in  1  write address valid
- aw_addr  in  32  write byte address
- aw_ready  out  1  write address accepted
- w_valid  in  1  write data valid
- w_data  in  32  write data, right-aligned
- w_strb  in  3  write size code
- w_ready  out  1  write data accepted
- b_valid  out  1  write response valid
- b_ready  in  1  master accepts write response

Behaviour:
- Size code encoding:
  - [2:1]: 00 = byte, 01 = half, 11 = word, 10 = reserved (treated as word).
  - [0]: read extension, 1 = zero-extend, 0 = sign-extend; ignored on writes and for word reads.
  - The fetch size code is 3'b110.
- Word index = (addr - BASE_ADDR) >> 2, taken modulo DEPTH (wrap-around, no error).
- Alignment: lane = addr[1:0] for bytes, addr[1] for halves; misaligned half/word ignores the low bits (aligned down).
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: ar_ready=1. On ar_valid, capture addr/strb and load the delay counter with LATENCY; go to R_WAIT, or to R_RESP if LATENCY=0.
  - R_WAIT: decrement; when the counter reaches 1, the next state is R_RESP.
  - On entry to R_RESP, r_data is registered from memory and formatted. r_valid=1 and r_data stays stable until r_ready; on r_valid&r_ready, go to R_IDLE.
  - ar_ready=0 outside R_IDLE; there is no pipelining of a second AR.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: aw_ready=1 while AW is not yet captured; w_ready=1 while W is not yet captured. AW and W may arrive in either order or in the same cycle.
  - Once both are captured, load the counter and go to W_WAIT (or W_RESP if LATENCY=0).
  - The memory write is committed on the transition into W_RESP: byte/half/word lanes are merged and the other bytes are preserved.
  - W_RESP: b_valid=1 until b_ready, then W_IDLE and both captured flags clear.
- Read/write collision: if R_RESP entry and the write commit fall in the same cycle on the same word, the read returns the pre-write data.
- Reset:
  - Both FSMs go to IDLE, counters to 0, captured flags clear.
  - Output values in reset: r_valid=0, b_valid=0, ar_ready=1, aw_ready=1, w_ready=1, r_data=0.
  - Memory contents are not reset.
  - A reset mid-transaction abandons it; a pending write not yet committed is not written.
- Latency: the response asserts LATENCY+1 cycles after the accepting handshake edge (LATENCY=0 gives the next cycle).

Optional Feature:
- AXIL_RAND_DELAY_EN:
  - Defined: each channel's counter load value is 1 + (lfsr[2:0]). Each channel has its own 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 for read and 8'h5A for write on reset, advancing every cycle. LATENCY is ignored.
  - Undefined: a fixed LATENCY is used, with no LFSR logic.

Decomposition:
- Package axil_pkg holds:
  - size-code constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11;
  - read-state enum {R_IDLE,R_WAIT,R_RESP} and write-state enum {W_IDLE,W_WAIT,W_RESP}, 2 bits each;
  - LFSR seeds and taps.
- Sub-module axil_delay_ctr, instantiated twice: inputs start, load value; output done. It contains the optional LFSR.
- Lane extract/merge stays as functions in the package.

Test Plan:
- Word write then read, LATENCY=2:
  - AW 0x8000_0010, W 0xDEADBEEF strb 3'b110, both in the same cycle: aw_ready/w_ready accept, b_valid exactly 3 cycles later.
  - AR 0x8000_0010 strb 3'b110 returns r_data 0xDEADBEEF 3 cycles after the handshake.
- Byte/half sub-word, memory word preset to 0xDEADBEEF:
  - Write byte 0x80 strb 3'b000 at 0x8000_0011: word becomes 0xDEAD80EF.
  - Read the same address with strb 3'b000 gives 0xFFFFFF80; with strb 3'b001 gives 0x00000080.
  - Read half at 0x8000_0012 with strb 3'b010 gives 0xFFFFDEAD.
- Backpressure: hold r_ready=0 for 5 cycles in R_RESP; r_valid and r_data stay stable and ar_ready stays 0. Releasing r_ready gives one handshake, then back to R_IDLE.
- Split write: W arrives 4 cycles before AW. w_ready drops after capture; no b_valid until AW is accepted; b_valid then follows LATENCY+1 cycles after AW.
- Collision and wrap, DEPTH=1024:
  - Address 0x8000_1000 aliases to word 0.
  - Read and write to the same word timed so R_RESP entry and the write commit coincide: the read returns the old value, and a subsequent read returns the new value.
- Reset mid-operation: assert reset while in W_WAIT. b_valid never asserts, the memory word is unchanged, and all readies are 1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types, size codes and lane helpers for the AXI-lite SRAM responder.
package axil_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

   localparam logic [7:0] LFSR_SEED_RD = 8'hA5;
   localparam logic [7:0] LFSR_SEED_WR = 8'h5A;
   // Fibonacci taps 8,6,5,4 as a mask on bits [7],[5],[4],[3]
   localparam logic [7:0] LFSR_TAPS    = 8'hB8;

   // Pick the addressed byte/half out of a word and extend; reserved size reads as word.
   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] sz);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz[2:1])
         SZ_BYTE: res = sz[0] ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: res = sz[0] ? {16'd0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] res;
      res = old;
      case (size)
         SZ_BYTE: res[{lane, 3'b000} +: 8]     = data[7:0];
         SZ_HALF: res[{lane[1], 4'b0000} +: 16] = data[15:0];
         default: res = data;
      endcase
      return res;
   endfunction
endpackage

// File: rtl/axil_delay_ctr.sv
// Response delay down-counter; done while the count sits at 1.
// With AXIL_RAND_DELAY_EN defined the load value comes from a private 8-bit LFSR.
module axil_delay_ctr import axil_pkg::*; #(
   parameter int CW = 16
`ifdef AXIL_RAND_DELAY_EN
   , parameter logic [7:0] SEED = LFSR_SEED_RD
`endif
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] load_val,
   output logic          done
);
   logic [CW-1:0] cnt;
   logic [CW-1:0] load_eff;

`ifdef AXIL_RAND_DELAY_EN
   logic [7:0] lfsr;
   logic       unused_load;
   assign unused_load = ^load_val;
   always_ff @(posedge clock) begin
      if (reset) lfsr <= SEED;
      else       lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
   end
   assign load_eff = CW'(lfsr[2:0]) + CW'(1);
`else
   assign load_eff = load_val;
`endif

   always_ff @(posedge clock) begin
      if (reset)           cnt <= '0;
      else if (start)      cnt <= load_eff;
      else if (cnt != '0)  cnt <= cnt - CW'(1);
   end

   assign done = (cnt == CW'(1));
endmodule

// File: rtl/axil_sram_resp.sv
// AXI-lite single-beat SRAM responder with independent read/write channel FSMs.
// Define AXIL_RAND_DELAY_EN for LFSR-randomised response latency (LATENCY ignored).
module axil_sram_resp import axil_pkg::*; #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          LATENCY   = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ar_valid,
   input  logic [31:0] ar_addr,
   input  logic [2:0]  ar_strb,
   output logic        ar_ready,
   output logic        r_valid,
   output logic [31:0] r_data,
   input  logic        r_ready,
   input  logic        aw_valid,
   input  logic [31:0] aw_addr,
   output logic        aw_ready,
   input  logic        w_valid,
   input  logic [31:0] w_data,
   input  logic [2:0]  w_strb,
   output logic        w_ready,
   output logic        b_valid,
   input  logic        b_ready
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = 16;
`ifdef AXIL_RAND_DELAY_EN
   localparam bit ZERO_LAT = 1'b0;
`else
   localparam bit ZERO_LAT = (LATENCY == 0);
`endif

   logic [31:0] mem [DEPTH];

   rd_state_t   rd_state, rd_next;
   wr_state_t   wr_state, wr_next;
   logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
   logic [2:0]  ar_strb_q;
   logic [1:0]  w_size_q;
   logic        aw_got, w_got;
   logic        ar_hs, aw_hs, w_hs, wr_both, rd_done, wr_done;
   logic        rd_start, wr_start, rd_load_resp, wr_commit;
   logic [31:0] rd_addr_eff, wr_addr_eff, wr_data_eff;
   logic [2:0]  rd_strb_eff;
   logic [1:0]  wr_size_eff;
   logic        unused_w_ext;

   assign unused_w_ext = w_strb[0];

   function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
      return IW'((a - BASE_ADDR) >> 2);
   endfunction

   // ---------------- read channel ----------------
   assign ar_hs        = ar_valid & ar_ready;
   assign rd_start     = ar_hs;
   // In IDLE the address is still on the bus (LATENCY=0 goes straight to RESP)
   assign rd_addr_eff  = (rd_state == R_IDLE) ? ar_addr : ar_addr_q;
   assign rd_strb_eff  = (rd_state == R_IDLE) ? ar_strb : ar_strb_q;
   assign rd_load_resp = (rd_next == R_RESP) && (rd_state != R_RESP) && !reset;

   always_ff @(posedge clock) begin
      if (reset) rd_state <= R_IDLE;
      else       rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_valid) rd_next = ZERO_LAT ? R_RESP : R_WAIT;
         R_WAIT:  if (rd_done)  rd_next = R_RESP;
         R_RESP:  if (r_ready)  rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      case (rd_state)
         R_IDLE:  ar_ready = 1'b1;
         R_RESP:  r_valid  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_data    <= '0;
         ar_addr_q <= '0;
         ar_strb_q <= '0;
      end else begin
         if (ar_hs) begin
            ar_addr_q <= ar_addr;
            ar_strb_q <= ar_strb;
         end
         if (rd_load_resp)
            r_data <= lane_extract(mem[word_idx(rd_addr_eff)], rd_addr_eff[1:0], rd_strb_eff);
      end
   end

   // ---------------- write channel ----------------
   assign aw_hs       = aw_valid & aw_ready;
   assign w_hs        = w_valid & w_ready;
   assign wr_both     = (aw_got | aw_hs) & (w_got | w_hs);
   assign wr_start    = (wr_state == W_IDLE) & wr_both;
   assign wr_addr_eff = aw_got ? aw_addr_q : aw_addr;
   assign wr_data_eff = w_got ? w_data_q : w_data;
   assign wr_size_eff = w_got ? w_size_q : w_strb[2:1];
   // Gated by reset so an abandoned write never reaches memory
   assign wr_commit   = (wr_next == W_RESP) && (wr_state != W_RESP) && !reset;

   always_ff @(posedge clock) begin
      if (reset) wr_state <= W_IDLE;
      else       wr_state <= wr_next;
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE:  if (wr_both) wr_next = ZERO_LAT ? W_RESP : W_WAIT;
         W_WAIT:  if (wr_done) wr_next = W_RESP;
         W_RESP:  if (b_ready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            aw_ready = ~aw_got;
            w_ready  = ~w_got;
         end
         W_RESP:  b_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_size_q  <= '0;
      end else if (wr_state == W_RESP && b_ready) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= aw_addr;
         end
         if (w_hs) begin
            w_got    <= 1'b1;
            w_data_q <= w_data;
            w_size_q <= w_strb[2:1];
         end
      end
   end

   // Nonblocking commit: a read loading in the same cycle sees the old word
   always_ff @(posedge clock) begin
      if (wr_commit)
         mem[word_idx(wr_addr_eff)] <= lane_merge(mem[word_idx(wr_addr_eff)], wr_data_eff,
                                                  wr_addr_eff[1:0], wr_size_eff);
   end

   axil_delay_ctr #(
      .CW(CW)
`ifdef AXIL_RAND_DELAY_EN
      , .SEED(LFSR_SEED_RD)
`endif
   ) u_rd_ctr (
      .clock(clock), .reset(reset), .start(rd_start), .load_val(CW'(LATENCY)), .done(rd_done)
   );

   axil_delay_ctr #(
      .CW(CW)
`ifdef AXIL_RAND_DELAY_EN
      , .SEED(LFSR_SEED_WR)
`endif
   ) u_wr_ctr (
      .clock(clock), .reset(reset), .start(wr_start), .load_val(CW'(LATENCY)), .done(wr_done)
   );
endmodule

// File: tb/tb_axil_sram_resp.sv
// Scoreboard bench for axil_sram_resp: directed transactions, queued expectations, monitor checks.
module tb_axil_sram_resp;
   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ar_valid = 1'b0, r_ready = 1'b1, aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b1;
   logic [31:0] ar_addr = '0, aw_addr = '0, w_data = '0;
   logic [2:0]  ar_strb = '0, w_strb = '0;
   logic        ar_ready, r_valid, aw_ready, w_ready, b_valid;
   logic [31:0] r_data;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] rd_q[$];
   int          wr_q[$];

   always #5 clock = ~clock;

   axil_sram_resp #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_strb(ar_strb), .ar_ready(ar_ready),
      .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
      .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
      .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_ready(w_ready),
      .b_valid(b_valid), .b_ready(b_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc;
      @(posedge clock);
      #1;
   endtask

   // Monitor: inputs settle at posedge+1, so posedge+2 shows what the next edge will accept
   always @(posedge clock) begin
      #2;
      if (r_valid && r_ready) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL r_unexpected: got response %h, expected none", r_data);
         end else chk("r_data", r_data, rd_q.pop_front());
      end
      if (b_valid && b_ready) begin
         if (wr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL b_unexpected: got write response, expected none");
         end else void'(wr_q.pop_front());
      end
   end

   task automatic issue_ar(input logic [31:0] addr, input logic [2:0] strb, input logic [31:0] exp);
      int n;
      rd_q.push_back(exp);
      ar_addr = addr; ar_strb = strb; ar_valid = 1'b1;
      chk("ar_ready", ar_ready, 1'b1);
      cyc;
      ar_valid = 1'b0;
      n = 1;
      while (!r_valid && n < 20) begin cyc; n++; end
      chk("r_latency", n, LAT + 1);
   endtask

   task automatic wait_r_idle;
      int n;
      n = 0;
      while (r_valid && n < 20) begin cyc; n++; end
      chk("r_release", r_valid, 1'b0);
   endtask

   task automatic do_rd(input logic [31:0] addr, input logic [2:0] strb, input logic [31:0] exp);
      issue_ar(addr, strb, exp);
      wait_r_idle;
   endtask

   task automatic do_wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] strb,
                        input int lead);
      int n;
      wr_q.push_back(1);
      aw_addr = addr; w_data = data; w_strb = strb;
      w_valid = 1'b1; aw_valid = (lead == 0);
      chk("w_ready", w_ready, 1'b1);
      if (lead == 0) chk("aw_ready", aw_ready, 1'b1);
      cyc;
      w_valid = 1'b0; aw_valid = 1'b0;
      if (lead > 0) begin
         for (int i = 1; i < lead; i++) begin
            chk("w_ready_low", w_ready, 1'b0);
            chk("b_early", b_valid, 1'b0);
            cyc;
         end
         chk("b_early", b_valid, 1'b0);
         aw_valid = 1'b1;
         chk("aw_ready", aw_ready, 1'b1);
         cyc;
         aw_valid = 1'b0;
      end
      n = 1;
      while (!b_valid && n < 20) begin cyc; n++; end
      chk("b_latency", n, LAT + 1);
      n = 0;
      while (b_valid && n < 20) begin cyc; n++; end
      chk("b_release", b_valid, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int rl, bl;
      // Reset state
      repeat (3) cyc;
      chk("rst_r_valid", r_valid, 1'b0);
      chk("rst_b_valid", b_valid, 1'b0);
      chk("rst_ar_ready", ar_ready, 1'b1);
      chk("rst_aw_ready", aw_ready, 1'b1);
      chk("rst_w_ready", w_ready, 1'b1);
      chk("rst_r_data", r_data, 32'h0);
      reset = 1'b0;
      cyc;

      // Word write then read
      do_wr(32'h8000_0010, 32'hDEAD_BEEF, 3'b110, 0);
      do_rd(32'h8000_0010, 3'b110, 32'hDEAD_BEEF);

      // Byte write and sub-word reads
      do_wr(32'h8000_0011, 32'h0000_0080, 3'b000, 0);
      do_rd(32'h8000_0010, 3'b110, 32'hDEAD_80EF);
      do_rd(32'h8000_0011, 3'b000, 32'hFFFF_FF80);
      do_rd(32'h8000_0011, 3'b001, 32'h0000_0080);
      do_rd(32'h8000_0012, 3'b010, 32'hFFFF_DEAD);
      do_rd(32'h8000_0012, 3'b011, 32'h0000_DEAD);
      do_rd(32'h8000_0013, 3'b110, 32'hDEAD_80EF);   // misaligned word aligns down
      do_rd(32'h8000_0010, 3'b100, 32'hDEAD_80EF);   // reserved size reads as word
      do_rd(32'h8000_0013, 3'b011, 32'h0000_DEAD);   // misaligned half aligns down

      // Backpressure on R
      r_ready = 1'b0;
      issue_ar(32'h8000_0010, 3'b110, 32'hDEAD_80EF);
      for (int i = 0; i < 5; i++) begin
         chk("bp_r_valid", r_valid, 1'b1);
         chk("bp_r_data", r_data, 32'hDEAD_80EF);
         chk("bp_ar_ready", ar_ready, 1'b0);
         cyc;
      end
      r_ready = 1'b1;
      cyc;
      chk("bp_r_done", r_valid, 1'b0);
      chk("bp_ar_ready_back", ar_ready, 1'b1);

      // Split write: W four cycles ahead of AW
      do_wr(32'h8000_0020, 32'h1234_5678, 3'b110, 4);
      do_rd(32'h8000_0022, 3'b011, 32'h0000_1234);
      do_rd(32'h8000_0020, 3'b000, 32'h0000_0078);

      // Wrap-around: 0x8000_1000 aliases word 0
      do_wr(32'h8000_1000, 32'hCAFE_F00D, 3'b110, 0);
      do_rd(32'h8000_0000, 3'b110, 32'hCAFE_F00D);
      do_rd(32'h8000_0003, 3'b000, 32'hFFFF_FFCA);

      // Collision: read entry and write commit on the same edge return old data
      rd_q.push_back(32'hCAFE_F00D);
      wr_q.push_back(1);
      ar_addr = 32'h8000_0000; ar_strb = 3'b110; ar_valid = 1'b1;
      aw_addr = 32'h8000_1000; w_data = 32'h1111_2222; w_strb = 3'b110;
      aw_valid = 1'b1; w_valid = 1'b1;
      cyc;
      ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
      rl = 0; bl = 0;
      for (int k = 1; k <= 6; k++) begin
         if (r_valid && rl == 0) rl = k;
         if (b_valid && bl == 0) bl = k;
         cyc;
      end
      chk("col_r_latency", rl, LAT + 1);
      chk("col_b_latency", bl, LAT + 1);
      do_rd(32'h8000_0000, 3'b110, 32'h1111_2222);

      // Half write merges upper lane only
      do_wr(32'h8000_0002, 32'h0000_BEEF, 3'b010, 0);
      do_rd(32'h8000_0000, 3'b110, 32'hBEEF_2222);

      // Reset while the write sits in W_WAIT
      aw_addr = 32'h8000_0010; w_data = 32'hA5A5_A5A5; w_strb = 3'b110;
      aw_valid = 1'b1; w_valid = 1'b1;
      cyc;
      aw_valid = 1'b0; w_valid = 1'b0;
      reset = 1'b1;
      cyc;
      reset = 1'b0;
      chk("mid_rst_ar_ready", ar_ready, 1'b1);
      chk("mid_rst_aw_ready", aw_ready, 1'b1);
      chk("mid_rst_w_ready", w_ready, 1'b1);
      chk("mid_rst_r_data", r_data, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("mid_rst_no_b", b_valid, 1'b0);
         cyc;
      end
      do_rd(32'h8000_0010, 3'b110, 32'hDEAD_80EF);

      repeat (3) cyc;
      chk("rd_q_empty", rd_q.size(), 0);
      chk("wr_q_empty", wr_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
